// File: rtl/timer_counter_3ch.sv
// timer_counter_3ch: three-channel 32-bit down-counter/timer in the 8253/8254 style.
// Each channel counts rising edges of its own slow count clock, sampled in clk.
// Each channel supports three modes: one-shot, rate generator and square wave.
// Build option CNT_READBACK_SEL_EN: counter_out becomes a registered mux selected by counter_ch.
// Without CNT_READBACK_SEL_EN, counter_out is a registered copy of channel 0's count.
module timer_counter_3ch (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clk0,
  input  logic        clk1,
  input  logic        clk2,
  input  logic        counter_we,
  input  logic [31:0] counter_val,
  input  logic [1:0]  counter_ch,
  output logic        counter0_OUT,
  output logic        counter1_OUT,
  output logic        counter2_OUT,
  output logic [31:0] counter_out
);

  typedef enum logic [1:0] {
    MODE_ONESHOT     = 2'b00,
    MODE_RATE        = 2'b01,
    MODE_SQUARE      = 2'b10,
    MODE_ONESHOT_ALT = 2'b11
  } mode_e;

  logic [31:0] cnt [3];
  logic [31:0] rld [3];
  logic [2:0]  armed;
  logic [2:0]  out_q;
  logic [2:0]  pulse;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  prev;
  logic [2:0]  tick;
  logic [2:0]  wr;
  logic [5:0]  ctrl;
  mode_e       mode [3];

  assign tick = sync2 & ~prev;

  // Decode each channel's mode field and its write strobe
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mode[i] = mode_e'(ctrl[2*i +: 2]);
      wr[i]   = counter_we && (counter_ch == 2'(i));
    end
  end

  // Two-flop synchronizer plus a delayed copy for rising-edge detection of the count clocks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {clk2, clk1, clk0};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Mode control register, written through channel select 11
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl <= '0;
    end else if (counter_we && counter_ch == 2'd3) begin
      ctrl <= counter_val[5:0];
    end
  end

  // Per-channel load, countdown, reload and terminal output; a load beats a same-cycle tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
        rld[i] <= '0;
      end
      armed <= '0;
      out_q <= '0;
      pulse <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr[i]) begin
          cnt[i]   <= counter_val;
          rld[i]   <= counter_val;
          out_q[i] <= 1'b0;
          pulse[i] <= 1'b0;
          armed[i] <= !((counter_val == 32'd0) &&
                        (mode[i] == MODE_RATE || mode[i] == MODE_SQUARE));
        end else begin
          if (pulse[i]) begin
            out_q[i] <= 1'b0;
            pulse[i] <= 1'b0;
          end
          if (tick[i] && armed[i]) begin
            case (mode[i])
              MODE_RATE: begin
                if (cnt[i] > 32'd1) begin
                  cnt[i]   <= cnt[i] - 32'd1;
                  out_q[i] <= 1'b0;
                end else begin
                  cnt[i]   <= rld[i];
                  out_q[i] <= 1'b1;
                  pulse[i] <= 1'b1;
                end
              end
              MODE_SQUARE: begin
                if (cnt[i] > 32'd1) begin
                  cnt[i] <= cnt[i] - 32'd1;
                end else begin
                  cnt[i]   <= rld[i];
                  out_q[i] <= ~out_q[i];
                end
              end
              default: begin
                if (cnt[i] > 32'd1) begin
                  cnt[i] <= cnt[i] - 32'd1;
                end else begin
                  cnt[i]   <= 32'd0;
                  out_q[i] <= 1'b1;
                  armed[i] <= 1'b0;
                end
              end
            endcase
          end
        end
      end
    end
  end

  // Registered readback towards the bus multiplexer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter_out <= '0;
    end else begin
`ifdef CNT_READBACK_SEL_EN
      case (counter_ch)
        2'd0:    counter_out <= cnt[0];
        2'd1:    counter_out <= cnt[1];
        2'd2:    counter_out <= cnt[2];
        default: counter_out <= {26'b0, ctrl};
      endcase
`else
      counter_out <= cnt[0];
`endif
    end
  end

  assign counter0_OUT = out_q[0];
  assign counter1_OUT = out_q[1];
  assign counter2_OUT = out_q[2];

endmodule

// File: tb/tb_timer_counter_3ch.sv
// tb_timer_counter_3ch: scoreboard bench for timer_counter_3ch.
// A rule-level reference model predicts the counts, outputs and output rising edges after each operation.
// A negedge monitor compares the DUT against the expectation queue whenever a sample is requested.
module tb_timer_counter_3ch;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        clk0 = 1'b0;
  logic        clk1 = 1'b0;
  logic        clk2 = 1'b0;
  logic        counter_we = 1'b0;
  logic [31:0] counter_val = '0;
  logic [1:0]  counter_ch = '0;
  logic        counter0_OUT;
  logic        counter1_OUT;
  logic        counter2_OUT;
  logic [31:0] counter_out;

  timer_counter_3ch dut (
    .clk          (clk),
    .rstn         (rstn),
    .clk0         (clk0),
    .clk1         (clk1),
    .clk2         (clk2),
    .counter_we   (counter_we),
    .counter_val  (counter_val),
    .counter_ch   (counter_ch),
    .counter0_OUT (counter0_OUT),
    .counter1_OUT (counter1_OUT),
    .counter2_OUT (counter2_OUT),
    .counter_out  (counter_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          sample_req = 1'b0;

  logic [31:0] m_cnt [3];
  logic [31:0] m_rld [3];
  bit          m_arm [3];
  bit          m_out [3];
  int          m_rise [3];
  logic [5:0]  m_ctrl;

  int          rise_cnt [3];
  int          hi1 = 0;
  logic [2:0]  prev_outs = 3'b000;
  logic [2:0]  now_o;

  // Reference model: readback value for a given select
  function automatic logic [31:0] exp_readback(input logic [1:0] sel);
    logic [31:0] r;
    r = m_cnt[0];
`ifdef CNT_READBACK_SEL_EN
    case (sel)
      2'd1:    r = m_cnt[1];
      2'd2:    r = m_cnt[2];
      2'd3:    r = {26'b0, m_ctrl};
      default: r = m_cnt[0];
    endcase
`else
    // The select has no effect in this build: channel 0 is always shown
    if (sel == 2'd3) r = m_cnt[0];
`endif
    return r;
  endfunction

  function automatic logic [31:0] pack_rises(input int r0, input int r1, input int r2);
    return 32'(r0) | (32'(r1) << 10) | (32'(r2) << 20);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = '0;
      m_rld[i] = '0;
      m_arm[i] = 1'b0;
      m_out[i] = 1'b0;
    end
    m_ctrl = '0;
  endtask

  task automatic model_write(input int ch, input logic [31:0] v);
    logic [1:0] md;
    if (ch == 3) begin
      m_ctrl = v[5:0];
    end else begin
      md = m_ctrl[2*ch +: 2];
      m_cnt[ch] = v;
      m_rld[ch] = v;
      m_out[ch] = 1'b0;
      m_arm[ch] = !(v == 32'd0 && (md == 2'b01 || md == 2'b10));
    end
  endtask

  task automatic model_tick(input int ch);
    logic [1:0] md;
    md = m_ctrl[2*ch +: 2];
    if (!m_arm[ch]) return;
    if (md == 2'b01) begin
      if (m_cnt[ch] > 1) begin
        m_cnt[ch]--;
      end else begin
        m_cnt[ch] = m_rld[ch];
        if (!m_out[ch]) m_rise[ch]++;
      end
      m_out[ch] = 1'b0;
    end else if (md == 2'b10) begin
      if (m_cnt[ch] > 1) begin
        m_cnt[ch]--;
      end else begin
        m_cnt[ch] = m_rld[ch];
        m_out[ch] = !m_out[ch];
        if (m_out[ch]) m_rise[ch]++;
      end
    end else begin
      if (m_cnt[ch] > 1) begin
        m_cnt[ch]--;
      end else begin
        m_cnt[ch] = 0;
        if (!m_out[ch]) m_rise[ch]++;
        m_out[ch] = 1'b1;
        m_arm[ch] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cclk(input int ch, input logic v);
    case (ch)
      0:       clk0 = v;
      1:       clk1 = v;
      default: clk2 = v;
    endcase
  endtask

  // op 0 = bus write to select ch, op 1 = one count-clock pulse on channel ch
  task automatic applyStimulus(input int op, input int ch, input logic [31:0] val);
    if (op == 0) begin
      counter_we  = 1'b1;
      counter_ch  = 2'(ch);
      counter_val = val;
      cyc(1);
      counter_we  = 1'b0;
      counter_ch  = 2'd0;
      model_write(ch, val);
      cyc(3);
    end else begin
      set_cclk(ch, 1'b1);
      cyc(4);
      set_cclk(ch, 1'b0);
      cyc(4);
      model_tick(ch);
    end
  endtask

  task automatic checkOutput(input string tag);
    sb_q.push_back('{0, exp_readback(counter_ch), {tag, " readback"}});
    sb_q.push_back('{1, {29'b0, m_out[2], m_out[1], m_out[0]}, {tag, " outs"}});
    sb_q.push_back('{2, pack_rises(m_rise[0], m_rise[1], m_rise[2]), {tag, " rises"}});
    sample_req = 1'b1;
    cyc(1);
    sample_req = 1'b0;
  endtask

  // Monitor: track output edges and drain the scoreboard when a sample is requested
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    now_o = {counter2_OUT, counter1_OUT, counter0_OUT};
    for (int i = 0; i < 3; i++)
      if (now_o[i] === 1'b1 && prev_outs[i] === 1'b0) rise_cnt[i]++;
    prev_outs = now_o;
    if (counter1_OUT === 1'b1) hi1++;
    if (sample_req) begin
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       got = counter_out;
          1:       got = {29'b0, now_o};
          2:       got = pack_rises(rise_cnt[0], rise_cnt[1], rise_cnt[2]);
          default: got = 32'(hi1);
        endcase
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < 3; i++) begin
      m_rise[i]   = 0;
      rise_cnt[i] = 0;
    end
    model_reset();
    #2 rstn = 1'b0;
    cyc(2);
    checkOutput("reset held");
    for (int c = 0; c < 3; c++) applyStimulus(1, c, '0);
    checkOutput("reset ticks");
    rstn = 1'b1;
    cyc(2);
    for (int c = 0; c < 3; c++) applyStimulus(1, c, '0);
    checkOutput("unloaded ticks");

    // One-shot countdown from 3, then hold high across extra ticks
    applyStimulus(0, 3, 32'h0);
    applyStimulus(0, 0, 32'd3);
    checkOutput("oneshot load");
    for (int t = 0; t < 8; t++) begin
      applyStimulus(1, 0, '0);
      checkOutput($sformatf("oneshot tick %0d", t + 1));
    end

    // One-shot loaded with zero fires on its first tick
    applyStimulus(0, 0, 32'd0);
    checkOutput("oneshot zero load");
    applyStimulus(1, 0, '0);
    checkOutput("oneshot zero tick");

    // Rate generator on channel 1, reload 4
    applyStimulus(0, 3, 32'h04);
    hi1 = 0;
    applyStimulus(0, 1, 32'd4);
    for (int t = 0; t < 12; t++) begin
      applyStimulus(1, 1, '0);
      checkOutput($sformatf("rate tick %0d", t + 1));
    end
    sb_q.push_back('{3, 32'd3, "rate pulse width total"});
    checkOutput("rate end");

    // Rate generator loaded with zero stays idle
    applyStimulus(0, 1, 32'd0);
    applyStimulus(1, 1, '0);
    checkOutput("rate zero load");

    // Square wave on channel 2, reload 2
    applyStimulus(0, 3, 32'h20);
    applyStimulus(0, 2, 32'd2);
    for (int t = 0; t < 8; t++) begin
      applyStimulus(1, 2, '0);
      checkOutput($sformatf("square tick %0d", t + 1));
    end

    // Write to channel 0 in the same cycle its tick is detected
    applyStimulus(0, 3, 32'h00);
    applyStimulus(0, 0, 32'd10);
    clk0 = 1'b1;
    cyc(2);
    counter_we  = 1'b1;
    counter_ch  = 2'd0;
    counter_val = 32'd7;
    cyc(1);
    counter_we = 1'b0;
    model_write(0, 32'd7);
    cyc(2);
    clk0 = 1'b0;
    cyc(4);
    checkOutput("collision");
    applyStimulus(1, 0, '0);
    checkOutput("after collision");

    // Readback select
    applyStimulus(0, 3, 32'h15);
    counter_ch = 2'd3;
    cyc(2);
    checkOutput("readback ctrl");
    counter_ch = 2'd2;
    cyc(2);
    checkOutput("readback ch2");
    counter_ch = 2'd0;
    cyc(2);

    // Reset in the middle of a count
    applyStimulus(0, 3, 32'h00);
    applyStimulus(0, 0, 32'd5);
    applyStimulus(1, 0, '0);
    checkOutput("before mid reset");
    #3 rstn = 1'b0;
    model_reset();
    cyc(1);
    checkOutput("mid reset");
    rstn = 1'b1;
    cyc(2);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    checkOutput("after mid reset");

    // Randomized mix of loads, mode writes and ticks
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)
        applyStimulus(0, 3, 32'($urandom_range(0, 63)));
      else if (r < 55)
        applyStimulus(0, int'($urandom_range(0, 2)), 32'($urandom_range(1, 6)));
      else
        applyStimulus(1, int'($urandom_range(0, 2)), '0);
      counter_ch = 2'($urandom_range(0, 3));
      cyc(2);
      checkOutput($sformatf("random %0d", n));
    end

    cyc(2);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
